// File: rtl/digit_marquee.sv
// Scrolling WIN-digit window over a circular frame of N_DIGITS digits plus GAP blanks.
// Define MARQUEE_BOUNCE_EN for ping-pong scrolling instead of circular wrap.
module digit_marquee #(
  parameter int N_DIGITS   = 3,
  parameter int WIN        = 2,
  parameter int GAP        = 1,
  parameter int DW         = 4,
  parameter int BLANK_CODE = 10,
  parameter int STEP_DIV   = 4,
  localparam int L  = N_DIGITS + GAP,
  localparam int PW = (L > 1) ? $clog2(L) : 1,
  localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   enable,
  input  logic                   load,
  input  logic                   dir,
  input  logic [N_DIGITS*DW-1:0] digits_in,
  output logic [WIN*DW-1:0]      win_out,
  output logic [PW-1:0]          pos,
  output logic                   wrap
);

  logic [N_DIGITS-1:0][DW-1:0] snap;
  logic [L-1:0][DW-1:0]        frame;
  logic [WIN-1:0][DW-1:0]      slot;
  logic [SW-1:0]               presc;
  logic                        tick;
  logic [PW-1:0]               pos_nxt;
  logic                        wrap_nxt;
  logic                        bdir, bdir_nxt;

  // Frame is MSD first: slot f holds digit N_DIGITS-1-f, then GAP blanks.
  for (genvar f = 0; f < L; f++) begin : g_frame
    if (f < N_DIGITS) begin : g_dig
      assign frame[f] = snap[N_DIGITS-1-f];
    end else begin : g_blk
      assign frame[f] = DW'(BLANK_CODE);
    end
  end

  // Both addends are below L, so one conditional subtract gives the modulo.
  for (genvar j = 0; j < WIN; j++) begin : g_slot
    localparam int OFF = N_DIGITS - 1 - j;
    logic [PW:0] sum, idx;
    always_comb begin
      sum = {1'b0, pos} + (PW+1)'(OFF);
      idx = (sum >= (PW+1)'(L)) ? sum - (PW+1)'(L) : sum;
    end
    assign slot[j] = frame[idx[PW-1:0]];
  end

  assign tick = (presc == SW'(STEP_DIV-1));

`ifdef MARQUEE_BOUNCE_EN
  logic dir_unused;
  assign dir_unused = dir;

  always_comb begin
    pos_nxt  = pos;
    bdir_nxt = bdir;
    wrap_nxt = 1'b0;
    if (L == WIN) begin
      pos_nxt  = '0;
      bdir_nxt = 1'b0;
      wrap_nxt = 1'b1;
    end else if (!bdir) begin
      pos_nxt  = pos + PW'(1);
      bdir_nxt = (pos_nxt == PW'(L-WIN));
      wrap_nxt = bdir_nxt;
    end else begin
      pos_nxt  = pos - PW'(1);
      bdir_nxt = (pos_nxt != '0);
      wrap_nxt = (pos_nxt == '0);
    end
  end
`else
  always_comb begin
    bdir_nxt = 1'b0;
    if (dir) pos_nxt = (pos == '0) ? PW'(L-1) : pos - PW'(1);
    else     pos_nxt = (pos == PW'(L-1)) ? '0 : pos + PW'(1);
    wrap_nxt = (pos_nxt == '0);
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      snap    <= '0;
      pos     <= '0;
      presc   <= '0;
      win_out <= '0;
      wrap    <= 1'b0;
      bdir    <= 1'b0;
    end else begin
      win_out <= slot;
      if (!enable) begin
        // Parked: transparent capture, and disable wins over a coincident tick.
        snap  <= digits_in;
        pos   <= '0;
        presc <= '0;
        wrap  <= 1'b0;
        bdir  <= 1'b0;
      end else begin
        if (load) snap <= digits_in;
        wrap <= 1'b0;
        if (tick) begin
          presc <= '0;
          pos   <= pos_nxt;
          wrap  <= wrap_nxt;
          bdir  <= bdir_nxt;
        end else begin
          presc <= presc + SW'(1);
        end
      end
    end
  end

endmodule
